// File: rtl/deb_multi.sv
// Multi-channel debouncer: 2-flop synchroniser + saturating stability counter per channel.
// Optional long-press pulse enabled by defining DEB_MULTI_LONG_PRESS_EN.
module deb_multi #(
  parameter int N          = 4,
  parameter int CNT_W      = 4,
  parameter int STABLE_CNT = 15,
  parameter int LONG_W     = 8,
  parameter int LONG_CNT   = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] long
);

  localparam logic [CNT_W-1:0]  STABLE_VAL = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
  localparam logic [LONG_W-1:0] LONG_VAL   = LONG_W'(LONG_CNT);
  localparam logic [LONG_W-1:0] LONG_ONE   = LONG_W'(1);

  // Out-of-range thresholds would make the counters never reach them.
  if (N < 1 || STABLE_CNT < 1 || STABLE_CNT > (2**CNT_W - 1) ||
      LONG_CNT < 1 || LONG_CNT > (2**LONG_W - 1)) begin : g_bad_param
    $error("deb_multi: illegal parameter value");
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    logic             s0_reg;
    logic             s1_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             out_reg;
    logic             rise_reg;
    logic             fall_reg;
    logic             changed;
    logic             stable;
    logic             out_next;

    assign changed  = s0_reg ^ s1_reg;
    assign stable   = (cnt_reg == STABLE_VAL);
    assign out_next = stable ? s1_reg : out_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s0_reg   <= 1'b0;
        s1_reg   <= 1'b0;
        cnt_reg  <= '0;
        out_reg  <= 1'b0;
        rise_reg <= 1'b0;
        fall_reg <= 1'b0;
      end else begin
        s0_reg <= in[gi];
        s1_reg <= s0_reg;
        if (changed) begin
          cnt_reg <= '0;
        end else if (!stable) begin
          cnt_reg <= cnt_reg + CNT_ONE;
        end
        out_reg  <= out_next;
        // Pulses are registered alongside out so they line up with the level change.
        rise_reg <= stable & s1_reg & ~out_reg;
        fall_reg <= stable & ~s1_reg & out_reg;
      end
    end

    assign out[gi]  = out_reg;
    assign rise[gi] = rise_reg;
    assign fall[gi] = fall_reg;

`ifdef DEB_MULTI_LONG_PRESS_EN
    logic [LONG_W-1:0] lc_reg;
    logic              fired_reg;
    logic              long_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lc_reg    <= '0;
        fired_reg <= 1'b0;
        long_reg  <= 1'b0;
      end else if (!out_reg) begin
        lc_reg    <= '0;
        fired_reg <= 1'b0;
        long_reg  <= 1'b0;
      end else begin
        long_reg <= 1'b0;
        if (lc_reg != LONG_VAL) begin
          lc_reg <= lc_reg + LONG_ONE;
        end else if (!fired_reg) begin
          // fired stays set until release so a held button pulses only once.
          long_reg  <= 1'b1;
          fired_reg <= 1'b1;
        end
      end
    end

    assign long[gi] = long_reg;
`else
    assign long[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_deb_multi.sv
// Directed bench for deb_multi (N=4, CNT_W=4, STABLE_CNT=3); long-press checks
// run only when DEB_MULTI_LONG_PRESS_EN is defined.
module tb_deb_multi;

  localparam int N = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in;
  logic [N-1:0] out;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic [N-1:0] long;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [N-1:0] in;
    logic [N-1:0] out;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
  } vec_t;

  vec_t tbl [19];

  deb_multi #(
    .N(4), .CNT_W(4), .STABLE_CNT(3), .LONG_W(8), .LONG_CNT(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in),
    .out(out), .rise(rise), .fall(fall), .long(long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*N-1:0] pk(input logic [N-1:0] o, input logic [N-1:0] r,
                                        input logic [N-1:0] f, input logic [N-1:0] l);
    return {o, r, f, l};
  endfunction

  task automatic check(input string name, input logic [4*N-1:0] want);
    logic [4*N-1:0] got;
    got = {out, rise, fall, long};
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: out/rise/fall/long got %h %h %h %h want %h %h %h %h", name,
               got[15:12], got[11:8], got[7:4], got[3:0],
               want[15:12], want[11:8], want[7:4], want[3:0]);
    end
  endtask

  initial begin
    for (int r = 0; r < 19; r++) begin
      tbl[r].in   = (r >= 4 && r <= 11) ? 4'b0001 : 4'b0000;
      tbl[r].out  = (r >= 9 && r <= 16) ? 4'b0001 : 4'b0000;
      tbl[r].rise = (r == 9)  ? 4'b0001 : 4'b0000;
      tbl[r].fall = (r == 17) ? 4'b0001 : 4'b0000;
    end

    rst_n = 1'b0;
    in    = '0;
    repeat (3) step();
    check("reset_state", '0);
    rst_n = 1'b1;

    // Idle inputs: nothing moves.
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("idle_%0d", i), '0);
    end

    // Channel 0 rise and fall from the vector table.
    for (int r = 0; r < 19; r++) begin
      in = tbl[r].in;
      step();
      check($sformatf("tbl_%0d", r), pk(tbl[r].out, tbl[r].rise, tbl[r].fall, 4'b0000));
      $display("tbl row %0d in=%b out=%b rise=%b fall=%b", r, in, out, rise, fall);
    end

    // Channel 1 glitches of 1..3 cycles are swallowed.
    for (int w = 1; w <= 3; w++) begin
      for (int i = 0; i < w + 6; i++) begin
        in = (i < w) ? 4'b0010 : 4'b0000;
        step();
        check($sformatf("glitch_w%0d_%0d", w, i), '0);
      end
      $display("glitch width %0d out=%b", w, out);
    end

    // A 4-cycle pulse is just long enough.
    for (int i = 0; i < 12; i++) begin
      in = (i < 4) ? 4'b0010 : 4'b0000;
      step();
      check($sformatf("pulse4_%0d", i),
            pk((i >= 5 && i <= 8) ? 4'b0010 : 4'b0000,
               (i == 5) ? 4'b0010 : 4'b0000,
               (i == 9) ? 4'b0010 : 4'b0000, 4'b0000));
    end
    $display("pulse4 done out=%b", out);

    // Channels 2 and 3 together; channel 3 bounces once.
    for (int i = 0; i < 10; i++) begin
      in = (i == 1) ? 4'b0100 : 4'b1100;
      step();
      check($sformatf("indep_%0d", i),
            pk({(i >= 7) ? 1'b1 : 1'b0, (i >= 5) ? 1'b1 : 1'b0, 2'b00},
               {(i == 7) ? 1'b1 : 1'b0, (i == 5) ? 1'b1 : 1'b0, 2'b00},
               4'b0000, 4'b0000));
    end
    $display("indep done out=%b", out);

    // Reset mid-count on channel 0 while channels 2/3 are high.
    in = 4'b1101;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("prerst_%0d", i), pk(4'b1100, 4'b0000, 4'b0000, 4'b0000));
    end
    rst_n = 1'b0;
    #1;
    check("rst_async", '0);
    step();
    check("rst_hold_a", '0);
    step();
    check("rst_hold_b", '0);
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("postrst_%0d", i),
            pk((i >= 6) ? 4'b1101 : 4'b0000, (i == 6) ? 4'b1101 : 4'b0000,
               4'b0000, 4'b0000));
    end
    $display("post-reset out=%b", out);

    in = '0;
    repeat (12) step();
    check("settle_low", '0);

`ifdef DEB_MULTI_LONG_PRESS_EN
    for (int i = 0; i < 41; i++) begin
      in = 4'b0001;
      step();
      check($sformatf("long_hold_%0d", i),
            pk((i >= 5) ? 4'b0001 : 4'b0000, (i == 5) ? 4'b0001 : 4'b0000,
               4'b0000, (i == 16) ? 4'b0001 : 4'b0000));
    end
    $display("long hold done out=%b", out);
    in = '0;
    repeat (12) step();
    check("long_settle", '0);
    for (int i = 0; i < 30; i++) begin
      in = (i < 8) ? 4'b0001 : 4'b0000;
      step();
      check($sformatf("long_short_%0d", i),
            pk((i >= 5 && i <= 12) ? 4'b0001 : 4'b0000, (i == 5) ? 4'b0001 : 4'b0000,
               (i == 13) ? 4'b0001 : 4'b0000, 4'b0000));
    end
    $display("long short press done out=%b", out);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
